// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier accumulate/readout path.
package mult_pkg;
  localparam int ACC_W_DEF = 24;
  localparam int PROD_W    = 16;
  localparam int BYTES     = ACC_W_DEF / 8;

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic              vld;
    logic [PROD_W-1:0] data;
  } prod_req_t;
endpackage

// File: rtl/mult_byte_ser.sv
// Snapshot register streamed LSB-first over a valid/ready byte port.
module mult_byte_ser #(
  parameter int NB = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [NB*8-1:0] data,
  input  logic            out_ready,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  output logic            done
);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0][7:0] snap;
  logic [IDX_W-1:0]   idx;
  logic               last;

  assign last     = (idx == IDX_W'(NB - 1));
  assign done     = out_valid && out_ready && last;
  // Zero when idle so a discarded readout never leaks onto the port.
  assign out_byte = out_valid ? snap[idx] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      snap      <= data;
      idx       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (last) begin
        idx       <= '0;
        out_valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_accum.sv
// Saturating product accumulator with snapshot readout; accumulation never stalls.
module mult_accum
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              clear,
  input  logic              rd_start,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              sat,
  output logic [CNT_W-1:0]  count
);
  localparam int NB = ACC_W / 8;

  state_t            state;
  prod_req_t         req;
  logic [ACC_W-1:0]  acc, acc_base, acc_nxt;
  logic [ACC_W:0]    sum;
  logic [CNT_W-1:0]  cnt_base, cnt_nxt;
  logic              sat_base, sat_nxt;
  logic              load, done;

  assign req  = '{vld: prod_valid, data: prod};
  assign load = (state == IDLE) && rd_start;

  // Clear resets the base first so a same-edge product lands on zero.
  always_comb begin
    acc_base = clear ? '0 : acc;
    cnt_base = clear ? '0 : count;
    sat_base = clear ? 1'b0 : sat;
    sum      = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, req.data};
    acc_nxt  = acc_base;
    cnt_nxt  = cnt_base;
    sat_nxt  = sat_base;
    if (req.vld) begin
      if (sum[ACC_W]) begin
        acc_nxt = '1;
        sat_nxt = 1'b1;
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
      if (cnt_base != '1) cnt_nxt = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      count <= cnt_nxt;
      sat   <= sat_nxt;
      case (state)
        IDLE: if (rd_start) begin
          state <= SEND;
          busy  <= 1'b1;
        end
        SEND: if (done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mult_byte_ser #(.NB(NB)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (acc),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .done      (done)
  );
endmodule

// File: doc/mult_accum.md
# mult_accum

Accumulator and result serializer directly downstream of the 8×8 array multiplier. Each valid 16-bit product is added into a saturating 24-bit accumulator. On request, the block snapshots the accumulator and streams it out LSB-first over an 8-bit valid/ready byte port, which the top level maps to `uo_out`. Accumulation continues during readout, so the multiplier never stalls.

## Interface
- `ACC_W`, 24: accumulator width; must be a multiple of 8 and at least 16.
- `CNT_W`, 4: width of the product counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. The top level drives it from inverted `rst_n`.
- `prod_valid`  in  1  product present this cycle.
- `prod`  in  16  unsigned product from the array multiplier.
- `clear`  in  1  synchronous clear of `acc`, `count` and `sat`.
- `rd_start`  in  1  request snapshot and readout.
- `out_byte`  out  8  current byte of the snapshot.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  consumer accepts `out_byte`.
- `busy`  out  1  readout in progress (state SEND).
- `sat`  out  1  sticky overflow flag.
- `count`  out  CNT_W  number of products accumulated, saturating at all-ones.

## Operation
- State machine states:
  - IDLE: no readout.
  - SEND: snapshot being streamed; `busy` = 1.
- Reset values: `acc`=0, `count`=0, `sat`=0, snapshot=0, byte index=0, state IDLE, `out_valid`=0, `out_byte`=0, `busy`=0.
- Accumulate, in any state, on each edge with `prod_valid`=1:
  - acc ← acc + zero-extended `prod`.
  - If the sum exceeds 2^ACC_W−1: acc ← all-ones and `sat` ← 1.
  - count ← count+1, unless already all-ones.
- Clear: on an edge with `clear`=1, acc, count and sat take their reset values, then the same-edge product is applied.
  - Result: `clear`+`prod_valid` together gives acc=prod, count=1, sat=0.
- Snapshot: in IDLE, `rd_start`=1 loads the snapshot with the pre-edge `acc`.
  - The same-edge product and same-edge clear do not affect the snapshot.
  - `rd_start`+`clear` together therefore performs read-and-clear.
- `rd_start` in SEND is ignored; no queueing.
- SEND sequence:
  - `out_byte` = snapshot[8·i+7 : 8·i] for byte index i.
  - Index i advances on each edge with `out_valid`&&`out_ready`.
  - After byte ACC_W/8−1 is accepted, return to IDLE; `out_valid` and `busy` fall on that edge.
- `out_byte` holds its value while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- When `out_valid`=0, `out_byte` is driven to 0.

## Timing
- Product accepted at edge N is visible on `acc`/`count`/`sat` after edge N (one-cycle latency).
- `rd_start` sampled at edge N gives `out_valid`=1 with byte 0 after edge N.
- With `out_ready` held high, the block sends one byte per cycle; a 24-bit readout ends after edge N+3.
- The earliest new `rd_start` is accepted at the edge after return to IDLE. There is no back-to-back overlap.
- `rst` asserted mid-SEND: outputs go to their reset values immediately (asynchronously); the partial readout is discarded.
- The ready/valid rule is standard: the producer never drops `out_valid` or changes `out_byte` before acceptance.

## Structure
- Shared package `mult_pkg` holds:
  - `ACC_W` default
  - `BYTES` = ACC_W/8
  - state enum {IDLE, SEND}
  - product width 16, shared with the array multiplier
- Sub-module `mult_byte_ser` contains the snapshot register, byte index counter and valid/ready output, with `load`/`data` in and the byte port out.
- The parent holds the accumulator, saturation logic, counter and state machine.

## Test plan
- Accumulate then read:
  - Stimulus: reset; products 0x00FF, 0x0101, 0xFE01, one per cycle; then `rd_start`, `out_ready`=1.
  - Response: bytes 0x01, 0x00, 0x01 on consecutive cycles (acc=0x010001), count=3, sat=0, `busy` high for exactly 3 cycles.
- Saturation:
  - Stimulus: 257 products of 0xFFFF.
  - Response: acc=0xFFFFFF, sat=1, count=15. A subsequent `clear` gives acc=0, sat=0, count=0.
- Backpressure:
  - Stimulus: snapshot 0xABCDEF; `out_ready` low for 5 cycles, then toggled every cycle.
  - Response: 0xEF held stable throughout the stall, then 0xCD and 0xAB each accepted once; no byte lost or duplicated.
- Simultaneous events:
  - Stimulus: acc=0x000010; `rd_start`+`clear`+`prod_valid`(0x0005) on one edge.
  - Response: streamed 0x10, 0x00, 0x00; acc=0x000005, count=1 after the edge. A `rd_start` pulsed during SEND is ignored.
- Accumulation during readout:
  - Stimulus: products 0x0002 every cycle while SEND is stalled.
  - Response: the snapshot is unchanged, and acc increments by 2 per cycle.
- Reset mid-operation:
  - Stimulus: assert `rst` after byte 0 is accepted.
  - Response: `out_valid`, `busy`, `acc`, `count`, `sat` go to 0 without waiting for a clock edge; the next `rd_start` streams 0x00, 0x00, 0x00.
